// File: rtl/fir_clip_pkg.sv
// Shared types and elaboration-time helpers for the FIR + clip engine.
package fir_clip_pkg;

    typedef enum logic [1:0] {
        BYPASS   = 2'd0,
        HARD     = 2'd1,
        SOFT     = 2'd2,
        HARD_ALT = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        SCALE = 2'd2,
        CLIP  = 2'd3
    } state_e;

    // Accumulator width: full product, growth over the taps, plus headroom for gain.
    function automatic int acc_w(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps) + 8;
    endfunction

    // Power-on coefficient for tap idx: the legacy 9-tap kernel, otherwise a box filter.
    function automatic int default_coef(input int taps, input int coef_w, input int idx);
        if (taps == 9 && coef_w > 2 && (idx == 3 || idx == 7)) begin
            return 2;
        end
        return 1;
    endfunction

endpackage

// File: rtl/fir_clip_engine_clip_shaper.sv
// Output shaper: bypass, hard clip or soft-knee clip of the scaled filter result.
module clip_shaper
    import fir_clip_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int ACC_W  = 44
) (
    input  logic signed [ACC_W-1:0]  y,
    input  mode_e                    mode,
    input  logic signed [DATA_W-1:0] sample,
    input  logic        [DATA_W-1:0] limit,
    output logic signed [DATA_W-1:0] result
);

    logic             neg;
    logic [ACC_W-1:0] mag;
    logic [ACC_W-1:0] lim;
    logic [ACC_W-1:0] knee;
    logic [ACC_W-1:0] soft_mag;
    logic [ACC_W-1:0] sel_mag;
    logic [ACC_W-1:0] clip_mag;

    // Work on the magnitude, compress above the knee in soft mode, clamp, restore sign.
    always_comb begin
        neg      = y[ACC_W-1];
        mag      = neg ? -y : y;
        lim      = ACC_W'(limit);
        knee     = lim >> 1;
        soft_mag = (mag <= knee) ? mag : knee + ((mag - knee) >> 2);
        sel_mag  = (mode == SOFT) ? soft_mag : mag;
        clip_mag = (sel_mag < lim) ? sel_mag : lim;
        result   = neg ? -DATA_W'(clip_mag) : DATA_W'(clip_mag);
        if (mode == BYPASS) begin
            result = sample;
        end
    end

endmodule

// File: rtl/fir_clip_engine.sv
// Time-multiplexed FIR (one tap per clock) followed by gain and a clip stage.
//
// Handshake: a sample is taken on any rising edge where in_valid && in_ready.
// in_ready is high only in IDLE; while low, in_valid is ignored and the producer
// holds its sample. out_valid is a one-cycle pulse; D_out holds between pulses.
module fir_clip_engine
    import fir_clip_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int TAPS   = 9,
    parameter int COEF_W = 8,
    parameter int SHIFT  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic [2:0]               gain,
    input  logic [DATA_W-1:0]        limit,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] D_in,
    input  logic                     coef_we,
    input  logic [4:0]               coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] D_out
);

    localparam int ACC_W = acc_w(DATA_W, COEF_W, TAPS);
    localparam int TAP_W = $clog2(TAPS);

    state_e                    state_q, state_d;
    logic signed [DATA_W-1:0]  dly_q [TAPS];
    logic signed [DATA_W-1:0]  dly_d [TAPS];
    logic signed [COEF_W-1:0]  coef_q [TAPS];
    logic signed [COEF_W-1:0]  coef_d [TAPS];
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [ACC_W-1:0]   y_q, y_d;
    logic [TAP_W-1:0]          tap_q, tap_d;
    mode_e                     mode_q, mode_d;
    logic [2:0]                gain_q, gain_d;
    logic [DATA_W-1:0]         limit_q, limit_d;
    logic signed [DATA_W-1:0]  d_out_q, d_out_d;
    logic                      out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0]  shaped;

    // dly_q[0] is the newest sample and stays put until the next accept,
    // so it doubles as the captured sample for bypass.
    clip_shaper #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_shaper (
        .y      (y_q),
        .mode   (mode_q),
        .sample (dly_q[0]),
        .limit  (limit_q),
        .result (shaped)
    );

    // Next-state and datapath: accept/coef writes in IDLE, one MAC per cycle, scale, register output.
    always_comb begin
        state_d     = state_q;
        dly_d       = dly_q;
        coef_d      = coef_q;
        acc_d       = acc_q;
        y_d         = y_q;
        tap_d       = tap_q;
        mode_d      = mode_q;
        gain_d      = gain_q;
        limit_d     = limit_q;
        d_out_d     = d_out_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (coef_we && (int'(coef_addr) < TAPS)) begin
                    coef_d[coef_addr[TAP_W-1:0]] = coef_wdata;
                end
                if (in_valid) begin
                    dly_d[0] = D_in;
                    for (int k = 1; k < TAPS; k++) begin
                        dly_d[k] = dly_q[k-1];
                    end
                    mode_d  = en ? mode_e'(mode) : BYPASS;
                    gain_d  = gain;
                    limit_d = limit;
                    acc_d   = '0;
                    tap_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + ACC_W'(dly_q[tap_q]) * ACC_W'(coef_q[tap_q]);
                if (tap_q == TAP_W'(TAPS - 1)) begin
                    state_d = SCALE;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            SCALE: begin
                y_d     = (acc_q >>> SHIFT) << gain_q;
                state_d = CLIP;
            end
            CLIP: begin
                d_out_d     = shaped;
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any sample and restores default coefficients.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            for (int i = 0; i < TAPS; i++) begin
                dly_q[i]  <= '0;
                coef_q[i] <= COEF_W'(default_coef(TAPS, COEF_W, i));
            end
            acc_q       <= '0;
            y_q         <= '0;
            tap_q       <= '0;
            mode_q      <= BYPASS;
            gain_q      <= '0;
            limit_q     <= '0;
            d_out_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dly_q       <= dly_d;
            coef_q      <= coef_d;
            acc_q       <= acc_d;
            y_q         <= y_d;
            tap_q       <= tap_d;
            mode_q      <= mode_d;
            gain_q      <= gain_d;
            limit_q     <= limit_d;
            d_out_q     <= d_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign D_out     = d_out_q;

endmodule

// File: tb/tb_fir_clip_engine.sv
// Bench for fir_clip_engine: directed cases plus randomized traffic against a sample-level model.
module tb_fir_clip_engine;

    localparam int DATA_W = 24;
    localparam int TAPS   = 9;
    localparam int COEF_W = 8;
    localparam int SHIFT  = 4;
    localparam int LAT    = TAPS + 2;
    localparam int PERIOD = TAPS + 3;

    logic                     clk;
    logic                     rst;
    logic                     en;
    logic [1:0]               mode;
    logic [2:0]               gain;
    logic [DATA_W-1:0]        limit;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] D_in;
    logic                     coef_we;
    logic [4:0]               coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic                     out_valid;
    logic signed [DATA_W-1:0] D_out;

    fir_clip_engine #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS),
        .COEF_W (COEF_W),
        .SHIFT  (SHIFT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .gain       (gain),
        .limit      (limit),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .D_in       (D_in),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .out_valid  (out_valid),
        .D_out      (D_out)
    );

    // ---------------- clock / cycle counter ----------------
    int cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic signed [63:0] got,
                            input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Sample-level view: history of accepted samples, current coefficient set,
    // and the time at which the engine is free again.
    longint hist [TAPS];
    longint mcoef [TAPS];
    logic signed [DATA_W-1:0] exp_q [$];
    int     due_q [$];
    int     acc_times [$];
    int     last_acc;
    bit     has_acc;

    function automatic void model_reset();
        for (int k = 0; k < TAPS; k++) begin
            hist[k]  = 0;
            mcoef[k] = (TAPS == 9 && (k == 3 || k == 7)) ? 2 : 1;
        end
        exp_q.delete();
        due_q.delete();
        has_acc = 1'b0;
    endfunction

    function automatic longint ref_out(input longint x, input int md, input bit e,
                                       input int g, input longint lim);
        longint acc;
        longint y;
        longint a;
        longint knee;
        acc = 0;
        for (int k = 0; k < TAPS; k++) acc += hist[k] * mcoef[k];
        y = (acc >>> SHIFT) * (longint'(1) << g);
        if (!e || md == 0) return x;
        a = (y < 0) ? -y : y;
        knee = lim / 2;
        if (md == 2 && a > knee) a = knee + (a - knee) / 4;
        if (a >= lim) a = lim;
        return (y < 0) ? -a : a;
    endfunction

    function automatic bit model_ready();
        return !has_acc || (cyc >= last_acc + PERIOD - 1);
    endfunction

    // Scoreboard: inputs are stable at the falling edge, so predict the next rising edge here.
    always @(negedge clk) begin
        if (rst) begin
            model_reset();
        end else begin
            bit rdy;
            bit due;
            longint e;
            rdy = model_ready();
            check_eq("in_ready", in_ready, rdy);
            due = (due_q.size() > 0) && (due_q[0] == cyc);
            check_eq("out_valid", out_valid, due);
            if (due) begin
                if (out_valid) check_eq("d_out", D_out, exp_q[0]);
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end
            if (coef_we && rdy && int'(coef_addr) < TAPS) mcoef[coef_addr] = coef_wdata;
            if (in_valid && rdy) begin
                for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = D_in;
                e = ref_out(D_in, int'(mode), en, int'(gain), longint'(limit));
                exp_q.push_back(DATA_W'(e));
                due_q.push_back(cyc + 1 + LAT);
                last_acc = cyc + 1;
                has_acc  = 1'b1;
                acc_times.push_back(cyc + 1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic signed [DATA_W-1:0] x);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("ready_seen", in_ready, 1);
        D_in     = x;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output logic signed [DATA_W-1:0] v);
        bit got = 1'b0;
        v = '0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (out_valid) begin
                v   = D_out;
                got = 1'b1;
            end
        end
        check_eq("out_seen", got, 1);
        @(posedge clk); #1;
    endtask

    task automatic run_check(input string tag, input logic signed [DATA_W-1:0] x,
                             input logic signed [DATA_W-1:0] exp);
        logic signed [DATA_W-1:0] v;
        send(x);
        wait_out(v);
        check_eq(tag, v, exp);
    endtask

    task automatic write_coef(input int addr, input int data);
        coef_addr  = 5'(addr);
        coef_wdata = COEF_W'(data);
        coef_we    = 1'b1;
        @(posedge clk); #1;
        coef_we    = 1'b0;
    endtask

    task automatic set_ctrl(input bit e, input int md, input int g, input int lim);
        en    = e;
        mode  = 2'(md);
        gain  = 3'(g);
        limit = DATA_W'(lim);
    endtask

    task automatic impulse_test(input string tag);
        int imp_tab [10] = '{1024, 1024, 1024, 2048, 1024, 1024, 1024, 2048, 1024, 0};
        set_ctrl(1'b1, 1, 0, 550000);
        for (int i = 0; i < 10; i++) run_check(tag, (i == 0) ? 24'sd16384 : 24'sd0, imp_tab[i]);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic signed [DATA_W-1:0] v;
        rst = 1'b1; en = 1'b1; mode = 2'd1; gain = '0; limit = DATA_W'(550000);
        in_valid = 1'b0; D_in = '0; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        model_reset();
        #1;
        check_eq("rst_d_out", D_out, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        impulse_test("impulse");

        // Hard clip on DC with the default kernel.
        for (int i = 0; i < 10; i++) send(24'sd8000000);
        wait_out(v);
        check_eq("hard_pos", v, 550000);
        for (int i = 0; i < 10; i++) send(-24'sd8000000);
        wait_out(v);
        check_eq("hard_neg", v, -550000);

        // Single-tap kernel of unity gain for soft clip and gain checks.
        write_coef(0, 16);
        for (int k = 1; k < TAPS; k++) write_coef(k, 0);
        set_ctrl(1'b1, 2, 0, 550000);
        run_check("soft_knee", 400000, 306250);
        run_check("soft_pass", 200000, 200000);
        run_check("soft_clip", 4000000, 550000);
        set_ctrl(1'b1, 1, 3, 550000);
        run_check("gain_pos", 50000, 400000);
        run_check("gain_neg", -100000, -550000);
        set_ctrl(1'b1, 2, 0, 0);
        run_check("limit_zero", 300000, 0);
        set_ctrl(1'b0, 1, 0, 550000);
        run_check("en_bypass", 4000000, 4000000);

        // Randomized samples, coefficients and controls; controls also change mid-flight.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 1) write_coef($urandom_range(0, 31), $urandom_range(0, 255));
            set_ctrl($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 7),
                     ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 8388607));
            send(DATA_W'($urandom));
            set_ctrl($urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 7),
                     $urandom_range(0, 8388607));
            wait_out(v);
        end

        // Back-to-back: in_valid held high, data and controls churn, coef_we pulses at random.
        acc_times.delete();
        in_valid = 1'b1;
        for (int c = 0; c < 62; c++) begin
            D_in = DATA_W'($urandom);
            set_ctrl($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 7),
                     $urandom_range(0, 8388607));
            coef_we    = ($urandom_range(0, 2) == 0);
            coef_addr  = 5'($urandom_range(0, TAPS - 1));
            coef_wdata = COEF_W'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        coef_we  = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        check_eq("accept_count", acc_times.size(), 6);
        for (int i = 1; i < acc_times.size(); i++)
            check_eq("accept_gap", acc_times[i] - acc_times[i-1], PERIOD);

        // Reset in the middle of MAC after coefficients were rewritten.
        write_coef(2, 77);
        set_ctrl(1'b1, 1, 0, 550000);
        send(24'sd123456);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("abort_out_valid", out_valid, 0);
        check_eq("abort_d_out", D_out, 0);
        check_eq("abort_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (LAT + 4) @(posedge clk);
        #1;
        check_eq("post_rst_d_out", D_out, 0);
        impulse_test("impulse_after_rst");

        repeat (5) @(posedge clk);
        #1;
        check_eq("drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_clip_engine.md
Name: fir_clip_engine

Overview:
Parametrised successor to the fixed 9-tap FIR + hard-clip distortion stage.
- Time-multiplexed MAC, one tap per clock, over a TAPS-deep delay line.
- Runtime-writable coefficients, pre-clip gain, and selectable hard/soft clip or bypass.
- Sits in the pedal datapath between the codec RX deserialiser and downstream effects; valid/ready sample handshake at the audio sample rate.

Parameters:
- DATA_W, 24, sample width (signed).
- TAPS, 9, filter length (2..32).
- COEF_W, 8, coefficient width (signed).
- SHIFT, 4, arithmetic right shift applied to the accumulator.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  0 forces bypass regardless of mode.
- mode  in  2  0 bypass, 1 hard clip, 2 soft clip, 3 treated as hard clip.
- gain  in  3  pre-clip left shift, 0..7.
- limit  in  DATA_W  positive clip threshold; default use 550000.
- in_valid  in  1  sample offered.
- in_ready  out  1  engine idle, can accept.
- D_in  in  DATA_W  signed input sample.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  5  tap index.
- coef_wdata  in  COEF_W  signed coefficient.
- out_valid  out  1  one-cycle pulse, D_out is new.
- D_out  out  DATA_W  signed output sample, held between pulses.

Behaviour:
Reset and control:
- Reset values: D_out=0, out_valid=0, in_ready=1, delay line all 0, state IDLE.
- Coefficients reset to DEFAULT_COEF: for TAPS=9 this is {1,1,1,2,1,1,1,2,1}; for other TAPS, all 1.
- Accept occurs on any edge with in_valid & in_ready. At accept:
  - D_in shifts into buf[0]; buf[k] <= buf[k-1].
  - mode, en, gain and limit are captured.
  - Changes to mode, en, gain or limit between accepts never affect an in-flight sample.

State machine:
- IDLE: in_ready=1.
- MAC: TAPS cycles. acc += buf[k]*coef[k] for k=0..TAPS-1; acc is cleared at accept.
- SCALE: 1 cycle. y = (acc >>> SHIFT) << gain, in ACC_W = DATA_W+COEF_W+clog2(TAPS)+8 bits.
- CLIP: 1 cycle. Registers D_out, pulses out_valid, returns to IDLE.

Timing:
- out_valid is high for exactly one cycle, TAPS+2 clocks after the accept edge.
- in_ready is high again in that same cycle, so maximum throughput is one sample per TAPS+3 clocks.
- in_valid while in_ready=0: sample not taken, no side effects. The producer must hold it; the engine never stores it.

Arithmetic:
- `>>>` is an arithmetic shift, rounding toward minus infinity.
- Multiply is signed by signed; the accumulator never overflows at ACC_W.

Output modes (constant latency in every mode):
- Bypass (mode 0 or en=0): D_out = captured D_in.
- Hard clip: |y| < limit gives D_out = y; otherwise D_out = sign(y)*limit.
- Soft clip, with knee = limit>>1:
  - |y| <= knee: passes unchanged.
  - Otherwise: m = knee + ((|y|-knee)>>2), then hard-clipped at limit, then sign restored.
- limit=0 in a clip mode: D_out=0.

Coefficient writes:
- Applied only in IDLE; coef_we in any other state is ignored.
- coef_addr >= TAPS is ignored.
- Write and accept on the same edge: the new coefficient is used for that sample.

Reset mid-operation:
- Aborts the computation with no out_valid.
- Coefficients return to DEFAULT_COEF.

Decomposition:
- Package fir_clip_pkg holds:
  - mode_e enum (BYPASS, HARD, SOFT, HARD_ALT).
  - state_e enum (IDLE, MAC, SCALE, CLIP).
  - ACC_W function.
  - DEFAULT_COEF function (TAPS, COEF_W).
- One sub-module, clip_shaper: combinational. Inputs are y (ACC_W), mode, captured sample and limit; output is a DATA_W result. It is registered by the parent in CLIP.

Test Plan:
- Impulse response: defaults (TAPS=9, SHIFT=4, gain 0, limit 550000, hard), one sample 16384 followed by zeros -> D_out sequence 1024,1024,1024,2048,1024,1024,1024,2048,1024, then 0.
- Hard clip: defaults, DC 8000000 for 10 samples -> steady D_out 550000; DC -8000000 -> -550000.
- Soft clip: write coef[0]=16, coef[1..8]=0, mode 2, limit 550000:
  - x=400000 -> 306250.
  - x=200000 -> 200000.
  - x=4000000 -> 550000.
- Gain: coef[0]=16, others 0, hard mode, gain 3:
  - x=50000 -> 400000.
  - x=-100000 -> -550000.
- Handshake: in_valid held high continuously -> accepts spaced exactly 12 clocks; each out_valid 11 clocks after its accept; coef_we pulsed during MAC leaves coefficients unchanged.
- Reset: assert rst during MAC after a prior coef write -> no out_valid, D_out=0, in_ready=1; subsequent impulse returns the default response.
